dma_down_frame_checker: RTL
===========================

Name: dma_down_frame_checker

Overview:
- Monitoring pass-through stage placed directly downstream of the MFB-to-DMA down converter, on the DMA down bus.
- Forwards every transaction unchanged with a registered, full-throughput skid buffer.
- Checks SOP/EOP framing and compares each transaction's word count with its header LENGTH field.
- Reports violations through a per-error pulse, an error code and saturating statistics counters.

Parameters:
- DATA_WIDTH, 512, DMA down bus data width in bits; must be a multiple of 32. DW_PER_WORD = DATA_WIDTH/32.
- HDR_WIDTH, 32, DMA down header width in bits. LENGTH occupies bits [10:0] and is expressed in dwords.
- PKT_CNT_WIDTH, 32, width of the transaction counter.
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- RX_DMA_HDR  in  HDR_WIDTH  header, valid on the SOP word.
- RX_DMA_DATA  in  DATA_WIDTH  data word.
- RX_DMA_SOP  in  1  start of transaction.
- RX_DMA_EOP  in  1  end of transaction.
- RX_DMA_SRC_RDY  in  1  input word valid.
- RX_DMA_DST_RDY  out  1  block can accept a word.
- TX_DMA_HDR  out  HDR_WIDTH  forwarded header.
- TX_DMA_DATA  out  DATA_WIDTH  forwarded data word.
- TX_DMA_SOP  out  1  forwarded SOP.
- TX_DMA_EOP  out  1  forwarded EOP.
- TX_DMA_SRC_RDY  out  1  output word valid.
- TX_DMA_DST_RDY  in  1  downstream ready.
- ERR_VLD  out  1  one-cycle error pulse.
- ERR_CODE  out  2  error code: 0 = DATA_NO_SOP, 1 = SOP_NO_EOP, 2 = EOP_EARLY, 3 = EOP_LATE.
- PKT_CNT  out  PKT_CNT_WIDTH  count of accepted SOP words.
- ERR_CNT  out  ERR_CNT_WIDTH  count of detected errors.

Behaviour:
- Transfer rules: an RX transfer occurs when RX_DMA_SRC_RDY and RX_DMA_DST_RDY are both 1. A TX transfer occurs when TX_DMA_SRC_RDY and TX_DMA_DST_RDY are both 1.
- Buffering: a 2-entry skid buffer (main register plus skid register).
  - RX_DMA_DST_RDY = NOT skid_full. It is a register output and has no combinational path from TX_DMA_DST_RDY.
  - Latency is 1 cycle from RX transfer to TX_DMA_SRC_RDY.
  - Sustains one word per cycle when TX_DMA_DST_RDY is held at 1.
  - Word order is preserved. Data, header, SOP and EOP pass through bit-exact; the block never drops or modifies a word, including erroneous ones.
- Checking: performed only on RX transfers. States are IDLE and IN_PKT; registers are exp_words (8 bits) and word_cnt (8 bits).
- Expected length: len = LENGTH, where LENGTH = 0 means 2048 dwords. exp_words = ceil(len / DW_PER_WORD).
- IDLE:
  - Word with SOP=1 and EOP=1: single-word transaction. If exp_words ≠ 1, report EOP_EARLY. Stay in IDLE.
  - Word with SOP=1 and EOP=0: latch exp_words, set word_cnt = 1, go to IN_PKT.
  - Word with SOP=0: report DATA_NO_SOP and stay in IDLE.
- IN_PKT:
  - Word with SOP=1: report SOP_NO_EOP, then treat the word as a new SOP exactly as in IDLE (the old transaction is abandoned).
  - Otherwise word_cnt is incremented.
  - On EOP: if word_cnt+1 < exp_words report EOP_EARLY; if word_cnt+1 > exp_words report EOP_LATE. Return to IDLE.
  - If word_cnt+1 = exp_words and EOP=0: report EOP_LATE once, at that word, and stay in IN_PKT until EOP arrives. No further error is reported on that EOP.
- Error reporting: at most one error per RX transfer.
  - ERR_VLD and ERR_CODE are registered and appear 1 cycle after the offending RX transfer.
  - ERR_CODE holds its last value while ERR_VLD = 0.
- Counters: PKT_CNT increments on every accepted SOP word, including one that triggers SOP_NO_EOP. ERR_CNT increments on every ERR_VLD pulse. Both saturate at all-ones.
- Reset values: TX_DMA_SRC_RDY = 0, RX_DMA_DST_RDY = 1 (from the first cycle after reset), ERR_VLD = 0, ERR_CODE = 0, PKT_CNT = 0, ERR_CNT = 0, state = IDLE, buffer empty.
  - TX data, header, SOP and EOP are don't-care while TX_DMA_SRC_RDY = 0.
  - Reset asserted mid-transaction discards buffered words and drops the partial transaction without reporting an error.

Decomposition:
- Shared package dma_bus_pack: LENGTH field range constant (10:0), DMA_DOWNHDR_WIDTH, and an enumerated error-code type.
- One sub-module, dma_skid_buffer: a generic 2-entry valid/ready register stage, instantiated once with width HDR_WIDTH + DATA_WIDTH + 2.
- The checker FSM and counters live in the top module.

Test Plan (DATA_WIDTH = 512, DW_PER_WORD = 16):
1. LENGTH = 40, 3 words SOP…EOP, TX ready held at 1 → output identical with 1-cycle latency, no ERR_VLD, PKT_CNT = 1.
2. LENGTH = 0, 128-word transaction → no error; the same transaction ending with EOP on word 127 → ERR_CODE = EOP_EARLY, ERR_CNT = 1.
3. LENGTH = 16, single SOP+EOP word, then a word with SOP=0 while IDLE → second word gives DATA_NO_SOP, and both words are forwarded.
4. LENGTH = 32, SOP, then a new SOP with LENGTH = 16 and EOP → SOP_NO_EOP reported once, PKT_CNT = 2, and the second transaction is accepted clean.
5. LENGTH = 16, SOP with no EOP, EOP on word 3 → a single EOP_LATE pulse, 1 cycle after word 1.
6. Random TX_DMA_DST_RDY (50%) with back-to-back traffic → no loss or reordering, RX_DMA_DST_RDY drops only when the skid is full, and reset mid-transaction clears state so the next clean transaction reports no error.

Source files
------------

// File: rtl/dma_bus_pack.sv
`default_nettype none
// ============================================================
// Package : dma_bus_pack
// Shared DMA down bus constants and checker enumerations.
// Rev     : 1.0
// ============================================================
package dma_bus_pack;

  localparam int DMA_DOWNHDR_WIDTH = 32;
  localparam int LEN_MSB           = 10;
  localparam int LEN_LSB           = 0;

  typedef enum logic [1:0] {
    ERR_DATA_NO_SOP = 2'd0,
    ERR_SOP_NO_EOP  = 2'd1,
    ERR_EOP_EARLY   = 2'd2,
    ERR_EOP_LATE    = 2'd3
  } err_code_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_down_frame_checker_if.sv
`default_nettype none
// ============================================================
// Interface : dma_down_frame_checker_if
// DMA down bus: header, data, framing and valid/ready handshake.
// Rev       : 1.0
// ============================================================
interface dma_down_frame_checker_if #(
  parameter int HDR_WIDTH  = 32,
  parameter int DATA_WIDTH = 512
);
  logic [HDR_WIDTH-1:0]  HDR;
  logic [DATA_WIDTH-1:0] DATA;
  logic                  SOP;
  logic                  EOP;
  logic                  SRC_RDY;
  logic                  DST_RDY;

  modport master (output HDR, DATA, SOP, EOP, SRC_RDY, input  DST_RDY);
  modport slave  (input  HDR, DATA, SOP, EOP, SRC_RDY, output DST_RDY);
endinterface
`default_nettype wire

// File: rtl/dma_skid_buffer.sv
`default_nettype none
// ============================================================
// Module : dma_skid_buffer
// Two-entry registered valid/ready stage, full throughput.
// Rev    : 1.0
// ============================================================
module dma_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_vld,
  output logic                  o_rdy,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_vld,
  input  wire logic             i_rdy
);

  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_main_vld;
  logic             r_in_rdy;

  // r_in_rdy low means the skid register holds a word behind the main one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
    end else if (r_in_rdy) begin
      if (i_vld) begin
        if (!r_main_vld || i_rdy) r_main_vld <= 1'b1;
        else                      r_in_rdy   <= 1'b0;
      end else if (i_rdy) begin
        r_main_vld <= 1'b0;
      end
    end else if (i_rdy) begin
      r_in_rdy <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_in_rdy && i_vld) begin
      if (!r_main_vld || i_rdy) r_main <= i_data;
      else                      r_skid <= i_data;
    end else if (!r_in_rdy && i_rdy) begin
      r_main <= r_skid;
    end
  end

  assign o_rdy  = r_in_rdy;
  assign o_vld  = r_main_vld;
  assign o_data = r_main;

endmodule
`default_nettype wire

// File: rtl/dma_down_frame_checker.sv
`default_nettype none
// ============================================================
// Module : dma_down_frame_checker
// DMA down pass-through with SOP/EOP framing and length checks.
// Rev    : 1.0
// ============================================================
module dma_down_frame_checker
  import dma_bus_pack::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int HDR_WIDTH     = DMA_DOWNHDR_WIDTH,
  parameter int PKT_CNT_WIDTH = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  wire logic                    CLK,
  input  wire logic                    RESET,
  dma_down_frame_checker_if.slave      RX_DMA,
  dma_down_frame_checker_if.master     TX_DMA,
  output logic                         ERR_VLD,
  output logic [1:0]                   ERR_CODE,
  output logic [PKT_CNT_WIDTH-1:0]     PKT_CNT,
  output logic [ERR_CNT_WIDTH-1:0]     ERR_CNT
);

  localparam int DW_PER_WORD = DATA_WIDTH / 32;
  localparam int BUS_WIDTH   = HDR_WIDTH + DATA_WIDTH + 2;

  logic [BUS_WIDTH-1:0] w_rx_bus;
  logic [BUS_WIDTH-1:0] w_tx_bus;
  logic                 w_rx_rdy;
  logic                 w_rx_xfer;

  assign w_rx_bus  = {RX_DMA.HDR, RX_DMA.DATA, RX_DMA.SOP, RX_DMA.EOP};
  assign w_rx_xfer = RX_DMA.SRC_RDY & w_rx_rdy;
  assign RX_DMA.DST_RDY = w_rx_rdy;
  assign {TX_DMA.HDR, TX_DMA.DATA, TX_DMA.SOP, TX_DMA.EOP} = w_tx_bus;

  dma_skid_buffer #(
    .WIDTH (BUS_WIDTH)
  ) u_skid (
    .clk    (CLK),
    .rst    (RESET),
    .i_data (w_rx_bus),
    .i_vld  (RX_DMA.SRC_RDY),
    .o_rdy  (w_rx_rdy),
    .o_data (w_tx_bus),
    .o_vld  (TX_DMA.SRC_RDY),
    .i_rdy  (TX_DMA.DST_RDY)
  );

  chk_state_t                r_state, w_state_n;
  logic [7:0]                r_exp_words, w_exp_n;
  logic [7:0]                r_word_cnt, w_cnt_n;
  logic                      r_late, w_late_n;
  logic                      r_err_vld;
  err_code_t                 r_err_code, w_code;
  logic                      w_err;
  logic                      w_sop_acc;
  logic [PKT_CNT_WIDTH-1:0]  r_pkt_cnt;
  logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;
  logic [11:0]               w_len;
  logic [7:0]                w_exp;
  logic [7:0]                w_cnt_inc;

  // LENGTH of zero encodes the maximum 2048-dword transfer
  assign w_len     = (RX_DMA.HDR[LEN_MSB:LEN_LSB] == '0) ? 12'd2048
                                                         : {1'b0, RX_DMA.HDR[LEN_MSB:LEN_LSB]};
  assign w_exp     = 8'((w_len + 12'(DW_PER_WORD - 1)) / 12'(DW_PER_WORD));
  assign w_cnt_inc = r_word_cnt + 8'd1;

  always_comb begin
    w_state_n = r_state;
    w_exp_n   = r_exp_words;
    w_cnt_n   = r_word_cnt;
    w_late_n  = r_late;
    w_err     = 1'b0;
    w_code    = r_err_code;
    w_sop_acc = 1'b0;
    if (w_rx_xfer) begin
      if (RX_DMA.SOP) begin
        w_sop_acc = 1'b1;
        if (r_state == ST_IN_PKT) begin
          w_err  = 1'b1;
          w_code = ERR_SOP_NO_EOP;
        end
        if (RX_DMA.EOP) begin
          w_state_n = ST_IDLE;
          if (!w_err && (w_exp != 8'd1)) begin
            w_err  = 1'b1;
            w_code = ERR_EOP_EARLY;
          end
        end else begin
          w_state_n = ST_IN_PKT;
          w_exp_n   = w_exp;
          w_cnt_n   = 8'd1;
          w_late_n  = 1'b0;
          if (!w_err && (w_exp == 8'd1)) begin
            w_err    = 1'b1;
            w_code   = ERR_EOP_LATE;
            w_late_n = 1'b1;
          end
        end
      end else if (r_state == ST_IDLE) begin
        w_err  = 1'b1;
        w_code = ERR_DATA_NO_SOP;
      end else begin
        w_cnt_n = w_cnt_inc;
        if (RX_DMA.EOP) begin
          w_state_n = ST_IDLE;
          if (!r_late) begin
            if (w_cnt_inc < r_exp_words) begin
              w_err  = 1'b1;
              w_code = ERR_EOP_EARLY;
            end else if (w_cnt_inc > r_exp_words) begin
              w_err  = 1'b1;
              w_code = ERR_EOP_LATE;
            end
          end
        end else if (!r_late && (w_cnt_inc == r_exp_words)) begin
          // overrun is flagged once here; the eventual EOP stays silent
          w_err    = 1'b1;
          w_code   = ERR_EOP_LATE;
          w_late_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_exp_words <= 8'd0;
      r_word_cnt  <= 8'd0;
      r_late      <= 1'b0;
      r_err_vld   <= 1'b0;
      r_err_code  <= ERR_DATA_NO_SOP;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_exp_words <= w_exp_n;
      r_word_cnt  <= w_cnt_n;
      r_late      <= w_late_n;
      r_err_vld   <= w_err;
      r_err_code  <= w_code;
      if (w_sop_acc && (r_pkt_cnt != '1)) r_pkt_cnt <= r_pkt_cnt + PKT_CNT_WIDTH'(1);
      if (w_err && (r_err_cnt != '1))     r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign ERR_VLD  = r_err_vld;
  assign ERR_CODE = r_err_code;
  assign PKT_CNT  = r_pkt_cnt;
  assign ERR_CNT  = r_err_cnt;

endmodule
`default_nettype wire
